// File: rtl/rst_seq_pkg.sv
// Shared types and default delays for the rst_seq reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        LOCK_STABLE = 3'd1,
        SENSOR_REL  = 3'd2,
        SYS_REL     = 3'd3,
        RUN         = 3'd4,
        SOFT_RST    = 3'd5
    } rst_state_e;

    localparam int DEF_LOCK_STABLE_CYC = 1000;
    localparam int DEF_SENSOR_DLY_CYC  = 10000;
    localparam int DEF_SYS_DLY_CYC     = 256;
    localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/rst_seq_cnt.sv
// Delay counter for rst_seq: synchronous clear, enable, terminal-count compare.
module rst_seq_cnt
    import rst_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == limit);

endmodule

// File: rtl/rst_seq.sv
// Power-on / lock-loss reset sequencer for the 100 MHz domain.
// Optional soft reset of system logic from RUN when RST_SEQ_SOFT_RST_EN is defined.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int SENSOR_DLY_CYC  = DEF_SENSOR_DLY_CYC,
    parameter int SYS_DLY_CYC     = DEF_SYS_DLY_CYC,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk_100m,
    input  logic rst_n,
    input  logic locked,
`ifdef RST_SEQ_SOFT_RST_EN
    input  logic soft_rst_req,
`endif
    output logic sensor_rst_n,
    output logic sys_rst_n,
    output logic rst_done
);

    localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] SENSOR_LIM = CNT_W'(SENSOR_DLY_CYC - 1);
    localparam logic [CNT_W-1:0] SYS_LIM    = CNT_W'(SYS_DLY_CYC - 1);

    rst_state_e       state_q, state_d;
    logic             sensor_rst_n_q, sensor_rst_n_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             rst_done_q, rst_done_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_limit;

    rst_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .limit    (cnt_limit),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d        = state_q;
        sensor_rst_n_d = sensor_rst_n_q;
        sys_rst_n_d    = sys_rst_n_q;
        rst_done_d     = rst_done_q;
        cnt_en         = 1'b0;
        cnt_limit      = '0;

        case (state_q)
            WAIT_LOCK: begin
                sensor_rst_n_d = 1'b0;
                sys_rst_n_d    = 1'b0;
                rst_done_d     = 1'b0;
                if (locked) state_d = LOCK_STABLE;
            end
            LOCK_STABLE: begin
                cnt_en    = 1'b1;
                cnt_limit = LOCK_LIM;
                if (cnt_tc) begin
                    state_d        = SENSOR_REL;
                    sensor_rst_n_d = 1'b1;
                end
            end
            SENSOR_REL: begin
                cnt_en    = 1'b1;
                cnt_limit = SENSOR_LIM;
                if (cnt_tc) begin
                    state_d     = SYS_REL;
                    sys_rst_n_d = 1'b1;
                end
            end
            SYS_REL: begin
                cnt_en    = 1'b1;
                cnt_limit = SYS_LIM;
                if (cnt_tc) begin
                    state_d    = RUN;
                    rst_done_d = 1'b1;
                end
            end
            RUN: begin
`ifdef RST_SEQ_SOFT_RST_EN
                if (soft_rst_req) begin
                    state_d     = SOFT_RST;
                    sys_rst_n_d = 1'b0;
                    rst_done_d  = 1'b0;
                end
`endif
            end
`ifdef RST_SEQ_SOFT_RST_EN
            SOFT_RST: begin
                cnt_en    = 1'b1;
                cnt_limit = SYS_LIM;
                if (cnt_tc) begin
                    state_d     = SYS_REL;
                    sys_rst_n_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d        = WAIT_LOCK;
                sensor_rst_n_d = 1'b0;
                sys_rst_n_d    = 1'b0;
                rst_done_d     = 1'b0;
            end
        endcase

        // Lock loss beats any terminal count seen in the same cycle.
        if ((state_q != WAIT_LOCK) && !locked) begin
            state_d        = WAIT_LOCK;
            sensor_rst_n_d = 1'b0;
            sys_rst_n_d    = 1'b0;
            rst_done_d     = 1'b0;
        end

        cnt_clr = (state_d != state_q) || (state_q == WAIT_LOCK) || (state_q == RUN);
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_LOCK;
            sensor_rst_n_q <= 1'b0;
            sys_rst_n_q    <= 1'b0;
            rst_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sensor_rst_n_q <= sensor_rst_n_d;
            sys_rst_n_q    <= sys_rst_n_d;
            rst_done_q     <= rst_done_d;
        end
    end

    assign sensor_rst_n = sensor_rst_n_q;
    assign sys_rst_n    = sys_rst_n_q;
    assign rst_done     = rst_done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: checkpoint table for the release sequence plus corner-case sequences.
module tb_rst_seq;

    localparam int L = 1000;
    localparam int S = 10000;
    localparam int Y = 256;

    logic clk_100m = 1'b0;
    logic rst_n;
    logic locked;
    logic soft_rst_req;
    logic sensor_rst_n;
    logic sys_rst_n;
    logic rst_done;

    int n_tests = 0;
    int n_fail  = 0;
    int rel     = 0;

    always #5 clk_100m = ~clk_100m;

    rst_seq #(
        .LOCK_STABLE_CYC (L),
        .SENSOR_DLY_CYC  (S),
        .SYS_DLY_CYC     (Y),
        .CNT_W           (16)
    ) dut (
        .clk_100m     (clk_100m),
        .rst_n        (rst_n),
        .locked       (locked),
`ifdef RST_SEQ_SOFT_RST_EN
        .soft_rst_req (soft_rst_req),
`endif
        .sensor_rst_n (sensor_rst_n),
        .sys_rst_n    (sys_rst_n),
        .rst_done     (rst_done)
    );

    // Expected outputs packed as {sensor_rst_n, sys_rst_n, rst_done}.
    typedef struct {
        string      name;
        int         off;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk_100m);
        #1;
        rel++;
    endtask

    task automatic run_to(input int off);
        while (rel < off) tick();
    endtask

    task automatic check(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {sensor_rst_n, sys_rst_n, rst_done};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end else begin
            $display("[TB] ok   %s: %b", name, act);
        end
    endtask

    // locked must already be 1; the first tick is the lock-sampling edge E.
    task automatic run_table(input string tag);
        tick();
        rel = 0;
        for (int i = 0; i < 8; i++) begin
            run_to(vecs[i].off);
            check({tag, "/", vecs[i].name}, vecs[i].exp);
        end
    endtask

    initial begin
        vecs[0] = '{"lock_edge",     0,         3'b000};
        vecs[1] = '{"sensor_before", L - 1,     3'b000};
        vecs[2] = '{"sensor_rise",   L,         3'b100};
        vecs[3] = '{"sys_before",    L + S - 1, 3'b100};
        vecs[4] = '{"sys_rise",      L + S,     3'b110};
        vecs[5] = '{"done_before",   L + S + Y - 1, 3'b110};
        vecs[6] = '{"done_rise",     L + S + Y,     3'b111};
        vecs[7] = '{"run_hold",      L + S + Y + 10, 3'b111};

        locked       = 1'b0;
        soft_rst_req = 1'b0;
        rst_n        = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_state", 3'b000);
        repeat (5) tick();
        check("reset_hold", 3'b000);
        rst_n = 1'b1;
        repeat (4) tick();
        check("wait_lock_idle", 3'b000);

        locked = 1'b1;
        run_table("power_on");

        // Lock loss in RUN: asserted one edge after the drop is sampled.
        locked = 1'b0;
        check("run_drop_pre", 3'b111);
        tick();
        check("run_drop_post", 3'b000);
        repeat (3) tick();
        check("run_drop_hold", 3'b000);

        // One-cycle glitch at LOCK_STABLE count 500 restarts the stable count.
        locked = 1'b1;
        tick();
        rel = 0;
        run_to(500);
        locked = 1'b0;
        tick();
        check("stable_glitch", 3'b000);
        locked = 1'b1;
        tick();
        rel = 0;
        run_to(L - 3);
        check("stable_orig_deadline", 3'b000);
        run_to(L - 1);
        check("restart_before", 3'b000);
        run_to(L);
        check("restart_rise", 3'b100);

        // Drop coincides with the SENSOR_REL terminal count.
        run_to(L + S - 1);
        check("tc_drop_pre", 3'b100);
        locked = 1'b0;
        tick();
        check("tc_drop_post", 3'b000);
        tick();
        check("tc_drop_hold", 3'b000);

        // Asynchronous reset pulse in SYS_REL.
        locked = 1'b1;
        tick();
        rel = 0;
        run_to(L + S + 100);
        check("sys_rel_mid", 3'b110);
        rst_n = 1'b0;
        #2;
        check("async_rst", 3'b000);
        tick();
        tick();
        check("async_rst_hold", 3'b000);
        rst_n = 1'b1;
        run_table("after_rst");

`ifdef RST_SEQ_SOFT_RST_EN
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        rel = 0;
        check("soft_enter", 3'b100);
        run_to(Y - 1);
        check("soft_hold", 3'b100);
        run_to(Y);
        check("soft_sys_rise", 3'b110);
        run_to(2 * Y - 1);
        check("soft_done_before", 3'b110);
        run_to(2 * Y);
        check("soft_done_rise", 3'b111);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
